maxpool_2x2_stage: RTL and testbench

//  Downstream stage of the 3x3 convolution filter. Consumes its raster-order 8-bit output stream
//  (pixel + valid strobe + end-of-image flag) and performs 2x2 stride-2 max pooling.

---
 rtl/maxpool_2x2_stage.sv | 150 +++++++++++++++
 tb/tb_maxpool_2x2_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_stage.sv
// Purpose : 2x2 stride-2 max pooling over a raster-order pixel stream from the 3x3 conv stage.
// Latency : one cycle from the odd-row/odd-col input pixel to its pooled output strobe.
// Backpress: none; one pixel per cycle is accepted indefinitely, frames may run back-to-back.
//
// Ports
//   clk_i          clock, all logic on rising edge
//   rst_i          synchronous active-high reset
//   pixel_i        conv output pixel (DATA_W bits, unsigned)
//   pixel_valid_i  pixel_i valid this cycle
//   image_done_i   upstream end-of-image flag; early arrival discards the frame
//   pixel_o        pooled pixel, holds its value between strobes
//   pixel_valid_o  one-cycle strobe per pooled output
//   pool_done_o    one-cycle pulse after the last pixel of a full frame
//   sync_err_o     one-cycle pulse when a frame was cut short by image_done_i
module maxpool_2x2_stage #(
    parameter int DATA_W = 8,
    parameter int IN_DIM = 26
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              pixel_valid_i,
    input  logic              image_done_i,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_valid_o,
    output logic              pool_done_o,
    output logic              sync_err_o
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int LBW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    // Columns/rows at or beyond this index are the odd trailing line: counted, not pooled.
    localparam logic [CW:0]   POOL_LIM = (CW + 1)'(2 * OUT_DIM);
    localparam logic [CW-1:0] LAST_IDX = CW'(IN_DIM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     r_row;
    logic [DATA_W-1:0] r_h;
    logic [DATA_W-1:0] r_pixel;
    logic              r_pixel_valid;
    logic              r_pool_done;
    logic              r_sync_err;

    // Half-row line buffer: one horizontal pair-max per output column, written on even rows.
    logic [DATA_W-1:0] r_lb [OUT_DIM];

    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_last;
    logic              w_in_pool;
    logic [LBW-1:0]    w_lb_idx;
    logic [DATA_W-1:0] w_lb_rd;
    logic [DATA_W-1:0] w_pair_max;
    logic [DATA_W-1:0] w_quad_max;
    logic              w_resync;

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_col_last   = (r_col == LAST_IDX);
    assign w_row_last   = (r_row == LAST_IDX);
    assign w_frame_last = pixel_valid_i && w_col_last && w_row_last;
    assign w_in_pool    = ({1'b0, r_col} < POOL_LIM) && ({1'b0, r_row} < POOL_LIM);

    // col>>1 always fits the buffer index for pooled columns; ignored columns never use it.
    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_lb_rd    = r_lb[w_lb_idx];
    assign w_pair_max = umax(r_h, pixel_i);
    assign w_quad_max = umax(w_lb_rd, w_pair_max);

    // An early end-of-image only matters mid-frame; on the last pixel it is redundant.
    assign w_resync = image_done_i && (r_state == ST_RUN) && !w_frame_last;

    // Line buffer needs no reset: every entry is written on an even row before it is read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && pixel_valid_i && w_in_pool && !r_row[0] && r_col[0]) begin
            r_lb[w_lb_idx] <= w_pair_max;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_h           <= '0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_pool_done   <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_pool_done   <= 1'b0;
            r_sync_err    <= 1'b0;

            // Datapath: even columns latch the left pixel, odd/odd closes a 2x2 window.
            if (pixel_valid_i && w_in_pool) begin
                if (!r_col[0]) begin
                    r_h <= pixel_i;
                end else if (r_row[0]) begin
                    r_pixel       <= w_quad_max;
                    r_pixel_valid <= 1'b1;
                end
            end

            // Raster position tracking and frame state.
            if (pixel_valid_i) begin
                if (w_frame_last) begin
                    r_col       <= '0;
                    r_row       <= '0;
                    r_state     <= ST_IDLE;
                    r_pool_done <= 1'b1;
                end else begin
                    r_state <= ST_RUN;
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= r_row + CW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
            end

            // Resync takes priority over the counter advance of a same-cycle pixel,
            // but that pixel's datapath effect above has already been applied.
            if (w_resync) begin
                r_col      <= '0;
                r_row      <= '0;
                r_state    <= ST_IDLE;
                r_sync_err <= 1'b1;
            end
        end
    end

    assign pixel_o       = r_pixel;
    assign pixel_valid_o = r_pixel_valid;
    assign pool_done_o   = r_pool_done;
    assign sync_err_o    = r_sync_err;

endmodule

// File: tb/tb_maxpool_2x2_stage.sv
// Purpose : directed and table-driven checks of maxpool_2x2_stage at IN_DIM 4, 5 and 26.
// Latency : outputs sampled #1 after the accepting edge or on the falling edge.
// Backpress: none; stimulus drives one input per cycle with optional idle gaps.
module tb_maxpool_2x2_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix;
    logic       vld;
    logic       done;

    always #5 clk = ~clk;

    logic [7:0] o4_pix, o5_pix, o26_pix;
    logic       o4_vld, o5_vld, o26_vld;
    logic       o4_pd, o5_pd, o26_pd;
    logic       o4_se, o5_se, o26_se;

    maxpool_2x2_stage #(.DATA_W(8), .IN_DIM(4)) u4 (
        .clk_i(clk), .rst_i(rst), .pixel_i(pix), .pixel_valid_i(vld), .image_done_i(done),
        .pixel_o(o4_pix), .pixel_valid_o(o4_vld), .pool_done_o(o4_pd), .sync_err_o(o4_se));

    maxpool_2x2_stage #(.DATA_W(8), .IN_DIM(5)) u5 (
        .clk_i(clk), .rst_i(rst), .pixel_i(pix), .pixel_valid_i(vld), .image_done_i(done),
        .pixel_o(o5_pix), .pixel_valid_o(o5_vld), .pool_done_o(o5_pd), .sync_err_o(o5_se));

    maxpool_2x2_stage #(.DATA_W(8), .IN_DIM(26)) u26 (
        .clk_i(clk), .rst_i(rst), .pixel_i(pix), .pixel_valid_i(vld), .image_done_i(done),
        .pixel_o(o26_pix), .pixel_valid_o(o26_vld), .pool_done_o(o26_pd), .sync_err_o(o26_se));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors, stamped with the cycle number of the edge that produced them.
    logic [7:0] q4v[$], q5v[$], q26v[$];
    int         q4s[$], q5s[$], q26s[$];
    int         pd4[$], pd5[$], pd26[$];
    int         se4[$], se5[$], se26[$];

    always @(negedge clk) begin
        if (o4_vld) begin q4v.push_back(o4_pix); q4s.push_back(cyc); end
        if (o5_vld) begin q5v.push_back(o5_pix); q5s.push_back(cyc); end
        if (o26_vld) begin q26v.push_back(o26_pix); q26s.push_back(cyc); end
        if (o4_pd) pd4.push_back(cyc);
        if (o5_pd) pd5.push_back(cyc);
        if (o26_pd) pd26.push_back(cyc);
        if (o4_se) se4.push_back(cyc);
        if (o5_se) se5.push_back(cyc);
        if (o26_se) se26.push_back(cyc);
    end

    typedef struct {
        logic [7:0] pix;
        logic       vld;
        logic       done;
        logic       evld;
        logic [7:0] epix;
        logic       epd;
        logic       ese;
    } vec_t;

    vec_t       tab[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         last_acc;
    int         acc_t[676];
    logic [7:0] img[676];
    logic [7:0] expq[$];
    int         exps[$];
    logic [7:0] gotv[$];
    int         gots[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] p, input logic v, input logic d);
        pix  = p;
        vld  = v;
        done = d;
        @(posedge clk);
        #1;
        last_acc = cyc;
        vld  = 1'b0;
        done = 1'b0;
    endtask

    task automatic clear_mon();
        q4v.delete(); q5v.delete(); q26v.delete();
        q4s.delete(); q5s.delete(); q26s.delete();
        pd4.delete(); pd5.delete(); pd26.delete();
        se4.delete(); se5.delete(); se26.delete();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        vld  = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic add_px(input logic [7:0] p, input logic v, input logic d, input logic ev,
                          input logic [7:0] ep, input logic epd, input logic ese);
        vec_t t;
        t.pix = p; t.vld = v; t.done = d;
        t.evld = ev; t.epix = ep; t.epd = epd; t.ese = ese;
        tab.push_back(t);
    endtask

    // 4x4 frame of pixels 0..15 (first n of them); pooled outputs 5,7,13,15.
    task automatic add_frame(input logic [7:0] prior, input int n, input logic done_last);
        for (int k = 0; k < n; k++) begin
            logic [7:0] h;
            logic       ev;
            logic       d;
            ev = (k == 5) || (k == 7) || (k == 13) || (k == 15);
            if (k < 5)       h = prior;
            else if (k < 7)  h = 8'd5;
            else if (k < 13) h = 8'd7;
            else if (k < 15) h = 8'd13;
            else             h = 8'd15;
            d = done_last && (k == n - 1);
            add_px(8'(k), 1'b1, d, ev, h, (k == 15), d && (k != 15));
        end
    endtask

    // Reference pooling straight from the stored image.
    task automatic build_expected(input int dim, input int base);
        for (int r = 0; r < dim / 2; r++) begin
            for (int c = 0; c < dim / 2; c++) begin
                logic [7:0] m;
                int         i0;
                i0 = base + 2 * r * dim + 2 * c;
                m = img[i0];
                if (img[i0 + 1] > m) m = img[i0 + 1];
                if (img[i0 + dim] > m) m = img[i0 + dim];
                if (img[i0 + dim + 1] > m) m = img[i0 + dim + 1];
                expq.push_back(m);
                exps.push_back(acc_t[i0 + dim + 1]);
            end
        end
    endtask

    task automatic check_stream(input string name);
        check({name, " count"}, gotv.size(), expq.size());
        for (int k = 0; k < expq.size(); k++) begin
            logic [31:0] a;
            logic [31:0] s;
            a = '1;
            s = '1;
            if (k < gotv.size()) begin
                a = 32'(gotv[k]);
                s = 32'(gots[k]);
            end
            check($sformatf("%s val%0d", name, k), a, 32'(expq[k]));
            check($sformatf("%s stamp%0d", name, k), s, 32'(exps[k]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        pix  = '0;
        vld  = 1'b0;
        done = 1'b0;
        do_reset();

        check("reset u4", {o4_pix, o4_vld, o4_pd, o4_se}, 32'h0);
        check("reset u5", {o5_pix, o5_vld, o5_pd, o5_se}, 32'h0);
        check("reset u26", {o26_pix, o26_vld, o26_pd, o26_se}, 32'h0);

        // Table: full frame (done on last pixel ignored), idle done ignored,
        // early done alone, fresh frame, early done with a producing pixel, fresh frame.
        add_frame(8'd0, 16, 1'b1);
        add_px(8'd0, 1'b0, 1'b1, 1'b0, 8'd15, 1'b0, 1'b0);
        add_frame(8'd15, 7, 1'b0);
        add_px(8'd0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1);
        add_frame(8'd5, 16, 1'b0);
        add_frame(8'd15, 8, 1'b1);
        add_frame(8'd7, 16, 1'b0);
        add_px(8'd0, 1'b0, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0);

        for (int i = 0; i < tab.size(); i++) begin
            pix  = tab[i].pix;
            vld  = tab[i].vld;
            done = tab[i].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d {pix,vld,done,err}", i), {o4_pix, o4_vld, o4_pd, o4_se},
                  {tab[i].epix, tab[i].evld, tab[i].epd, tab[i].ese});
        end
        vld  = 1'b0;
        done = 1'b0;

        // Odd side: trailing column and row ignored, done six cycles after last strobe.
        do_reset();
        for (int i = 0; i < 25; i++) begin
            send(8'(i), 1'b1, 1'b0);
            acc_t[i] = last_acc;
        end
        send(8'd0, 1'b0, 1'b0);
        send(8'd0, 1'b0, 1'b0);
        expq.delete(); exps.delete();
        expq.push_back(8'd6);  exps.push_back(acc_t[6]);
        expq.push_back(8'd8);  exps.push_back(acc_t[8]);
        expq.push_back(8'd16); exps.push_back(acc_t[16]);
        expq.push_back(8'd18); exps.push_back(acc_t[18]);
        gotv = q5v; gots = q5s;
        check_stream("dim5");
        check("dim5 done count", pd5.size(), 1);
        check("dim5 done stamp", (pd5.size() > 0) ? pd5[0] : -1, acc_t[24]);
        check("dim5 done after last strobe",
              (pd5.size() > 0 && q5s.size() > 3) ? pd5[0] - q5s[3] : -1, 6);
        check("dim5 sync_err count", se5.size(), 0);

        // Full-size frame with random data and random idle gaps.
        do_reset();
        for (int i = 0; i < 676; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int g = 0; g < gap; g++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            img[i] = 8'($urandom_range(0, 255));
            send(img[i], 1'b1, 1'b0);
            acc_t[i] = last_acc;
        end
        send(8'd0, 1'b0, 1'b0);
        send(8'd0, 1'b0, 1'b0);
        expq.delete(); exps.delete();
        build_expected(26, 0);
        gotv = q26v; gots = q26s;
        check_stream("dim26");
        check("dim26 done count", pd26.size(), 1);
        check("dim26 done stamp", (pd26.size() > 0) ? pd26[0] : -1, acc_t[675]);
        check("dim26 sync_err count", se26.size(), 0);

        // Two 4x4 frames back-to-back, 255/0 mix.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] p;
            if (i < 16) p = (i % 3 == 0) ? 8'd255 : 8'd0;
            else        p = ((i - 16) % 5 == 1) ? 8'd255 : 8'd0;
            send(p, 1'b1, 1'b0);
            acc_t[i] = last_acc;
        end
        send(8'd0, 1'b0, 1'b0);
        expq.delete(); exps.delete();
        expq.push_back(8'd255); exps.push_back(acc_t[5]);
        expq.push_back(8'd255); exps.push_back(acc_t[7]);
        expq.push_back(8'd255); exps.push_back(acc_t[13]);
        expq.push_back(8'd255); exps.push_back(acc_t[15]);
        expq.push_back(8'd255); exps.push_back(acc_t[21]);
        expq.push_back(8'd255); exps.push_back(acc_t[23]);
        expq.push_back(8'd0);   exps.push_back(acc_t[29]);
        expq.push_back(8'd255); exps.push_back(acc_t[31]);
        gotv = q4v; gots = q4s;
        check_stream("b2b");
        check("b2b done count", pd4.size(), 2);
        check("b2b done0 stamp", (pd4.size() > 0) ? pd4[0] : -1, acc_t[15]);
        check("b2b done1 stamp", (pd4.size() > 1) ? pd4[1] : -1, acc_t[31]);
        check("b2b sync_err count", se4.size(), 0);

        // Reset mid-frame, then a fresh descending frame.
        do_reset();
        for (int i = 0; i < 6; i++) send(8'(i), 1'b1, 1'b0);
        rst  = 1'b1;
        pix  = 8'd9;
        vld  = 1'b1;
        done = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        vld  = 1'b0;
        done = 1'b0;
        check("midrst outputs", {o4_pix, o4_vld, o4_pd, o4_se}, 32'h0);
        clear_mon();
        send(8'd0, 1'b0, 1'b0);
        check("midrst no pulses", pd4.size() + se4.size() + q4v.size(), 0);
        for (int i = 0; i < 16; i++) begin
            send(8'(15 - i), 1'b1, 1'b0);
            acc_t[i] = last_acc;
        end
        send(8'd0, 1'b0, 1'b0);
        expq.delete(); exps.delete();
        expq.push_back(8'd15); exps.push_back(acc_t[5]);
        expq.push_back(8'd13); exps.push_back(acc_t[7]);
        expq.push_back(8'd7);  exps.push_back(acc_t[13]);
        expq.push_back(8'd5);  exps.push_back(acc_t[15]);
        gotv = q4v; gots = q4s;
        check_stream("postrst");
        check("postrst done count", pd4.size(), 1);
        check("postrst done stamp", (pd4.size() > 0) ? pd4[0] : -1, acc_t[15]);
        check("postrst sync_err count", se4.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
